filter_peak_sched: RTL and testbench

FILTER_PEAK_SCHED -- requirements
Module: filter_peak_sched

---
 rtl/filter_peak_sched.sv | 140 ++++++++++++++
 tb/tb_filter_peak_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/filter_peak_sched.sv
`timescale 1ns/1ps
// filter_peak_sched
//   Tracks the signed peak of N_CH filter outputs over fixed acquisition
//   windows of WINDOW_LEN clocks. At the end of each window the peaks are
//   snapshotted and streamed out one channel per word over a valid/ready
//   handshake. A window that completes while a readout is still in progress
//   is dropped, and the sticky overrun flag is set.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   enable     1 = acquire windows back-to-back, 0 = idle / abort window
//   ch_data    N_CH signed samples, channel i at [i*DATA_W +: DATA_W]
//   out_ready  downstream ready
//   out_valid  result word valid
//   out_data   window peak of channel out_ch
//   out_ch     channel index of out_data
//   out_last   marks the word for channel N_CH-1
//   overrun    sticky: a window snapshot was dropped
module filter_peak_sched #(
  parameter int N_CH       = 6,
  parameter int DATA_W     = 16,
  parameter int WINDOW_LEN = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [N_CH*DATA_W-1:0] ch_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [2:0]             out_ch,
  output logic                   out_last,
  output logic                   overrun
);

  localparam int CNT_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [2:0] CH_LAST = 3'(N_CH - 1);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [0:0] A_IDLE = 1'b0;
  localparam logic [0:0] A_ACQ  = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_SEND = 1'b1;

  function automatic logic signed [DATA_W-1:0] max_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  logic [0:0]               acq_state;
  logic [0:0]               rd_state;
  logic [CNT_W-1:0]         win_cnt;
  logic [2:0]               rd_ch;
  logic signed [DATA_W-1:0] sample_p0 [N_CH];
  logic signed [DATA_W-1:0] peak_p0   [N_CH];
  logic signed [DATA_W-1:0] snap_p1   [N_CH];

  logic sample_en;
  logic vld_p0;      // last sample of a window is present this cycle
  logic xfer;
  logic xfer_last;
  logic snap_load;
  logic snap_drop;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sample_p0[i] = $signed(ch_data[i*DATA_W +: DATA_W]);
    end
  end

  // ---- stage p0: window counter and running peaks ----
  assign sample_en = (acq_state == A_ACQ) && enable;
  assign vld_p0    = sample_en && (win_cnt == CNT_LAST);

  // Every path other than a mid-window sample (idle, entry, abort, window
  // end) leaves the counter at 0 and the peaks at the most-negative value,
  // so the next window always starts from fresh samples only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acq_state <= A_IDLE;
      win_cnt   <= '0;
      for (int i = 0; i < N_CH; i++) peak_p0[i] <= MOST_NEG;
    end else begin
      acq_state <= enable ? A_ACQ : A_IDLE;
      if (sample_en && !vld_p0) begin
        win_cnt <= win_cnt + CNT_W'(1);
        for (int i = 0; i < N_CH; i++) peak_p0[i] <= max_signed(peak_p0[i], sample_p0[i]);
      end else begin
        win_cnt <= '0;
        for (int i = 0; i < N_CH; i++) peak_p0[i] <= MOST_NEG;
      end
    end
  end

  // ---- stage p1: snapshot and readout ----
  assign xfer      = out_valid && out_ready;
  assign xfer_last = xfer && (rd_ch == CH_LAST);
  // A finishing window may only replace the snapshot when no readout is in
  // flight, or when the final word of that readout leaves on this same edge.
  assign snap_load = vld_p0 && ((rd_state == R_IDLE) || xfer_last);
  assign snap_drop = vld_p0 && !snap_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) snap_p1[i] <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < N_CH; i++) snap_p1[i] <= max_signed(peak_p0[i], sample_p0[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state <= R_IDLE;
      rd_ch    <= '0;
      overrun  <= 1'b0;
    end else begin
      if (snap_drop) overrun <= 1'b1;
      if (snap_load) begin
        rd_state <= R_SEND;
        rd_ch    <= '0;
      end else if (xfer_last) begin
        rd_state <= R_IDLE;
        rd_ch    <= '0;
      end else if (xfer) begin
        rd_ch <= rd_ch + 3'd1;
      end
    end
  end

  // Outputs decode straight from registers, so they hold while out_ready=0.
  assign out_valid = (rd_state == R_SEND);
  assign out_ch    = rd_ch;
  assign out_last  = out_valid && (rd_ch == CH_LAST);
  assign out_data  = out_valid ? snap_p1[rd_ch] : '0;

endmodule

// File: tb/tb_filter_peak_sched.sv
`timescale 1ns/1ps
// Directed bench for filter_peak_sched with WINDOW_LEN=8, N_CH=6, DATA_W=16.
module tb_filter_peak_sched;

  localparam int N_CH = 6;
  localparam int DW   = 16;
  localparam int WL   = 8;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [N_CH*DW-1:0] ch_data;
  logic               out_ready;
  logic               out_valid;
  logic [DW-1:0]      out_data;
  logic [2:0]         out_ch;
  logic               out_last;
  logic               overrun;

  int n_cmp = 0;
  int n_err = 0;

  filter_peak_sched #(
    .N_CH(N_CH),
    .DATA_W(DW),
    .WINDOW_LEN(WL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ch_data(ch_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_last(out_last),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ramp(input int base, input int k);
    for (int i = 0; i < N_CH; i++) ch_data[i*DW +: DW] = DW'(base + k + 100*i);
  endtask

  task automatic set_const(input logic [DW-1:0] v);
    for (int i = 0; i < N_CH; i++) ch_data[i*DW +: DW] = v;
  endtask

  task automatic feed_ramp(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      set_ramp(base, k);
      tick();
    end
  endtask

  // Drains one full readout with out_ready=1. Expected word c is either the
  // constant cval or the ramp peak base+7+100*c.
  task automatic read_words(input string tag, input bit cst, input logic [DW-1:0] cval, input int base);
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      exp = cst ? cval : DW'(base + 7 + 100*c);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_ch"},    32'(out_ch),    32'(c));
      chk({tag, "_data"},  32'(out_data),  32'(exp));
      chk({tag, "_last"},  32'(out_last),  32'(c == N_CH-1));
      tick();
    end
    chk({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    ch_data   = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_valid",   32'(out_valid), 32'd0);
    chk("rst_data",    32'(out_data),  32'd0);
    chk("rst_ch",      32'(out_ch),    32'd0);
    chk("rst_last",    32'(out_last),  32'd0);
    chk("rst_overrun", 32'(overrun),   32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Ramp per channel: peaks 7,107,...,507, first word right after sample 8.
    enable = 1'b1;
    tick();
    feed_ramp(0, WL-1);
    chk("t1_lat_pre", 32'(out_valid), 32'd0);
    set_ramp(0, WL-1);
    tick();
    enable = 1'b0;
    read_words("t1", 1'b0, '0, 0);

    // Constant -5: signed peak must be 0xFFFB, not 0.
    enable = 1'b1;
    tick();
    for (int k = 0; k < WL; k++) begin
      set_const(16'hFFFB);
      tick();
    end
    enable = 1'b0;
    read_words("t2", 1'b1, 16'hFFFB, 0);
    chk("t2_overrun", 32'(overrun), 32'd0);

    // Last word leaves on the same edge as the next snapshot: restart, no overrun.
    enable = 1'b1;
    tick();
    feed_ramp(0, WL);
    for (int k = 0; k < WL; k++) begin
      out_ready = (k >= 2);
      set_ramp(2000, k);
      tick();
    end
    enable = 1'b0;
    chk("t4_overrun", 32'(overrun), 32'd0);
    read_words("t4", 1'b0, '0, 2000);
    chk("t4_overrun_end", 32'(overrun), 32'd0);

    // Abort at sample 4 with large values; re-enabled window sees only small ones.
    enable = 1'b1;
    tick();
    feed_ramp(5000, 4);
    enable = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t5_no_word", 32'(out_valid), 32'd0);
    end
    enable = 1'b1;
    tick();
    feed_ramp(0, WL);
    enable = 1'b0;
    read_words("t5", 1'b0, '0, 0);

    // Stall 20 cycles on ch0; the next window's snapshot is dropped.
    out_ready = 1'b0;
    enable = 1'b1;
    tick();
    feed_ramp(0, WL);
    for (int k = 0; k < WL; k++) begin
      set_ramp(1000, k);
      tick();
      if (k == WL-2) chk("t3_overrun_pre", 32'(overrun), 32'd0);
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_ch",    32'(out_ch),    32'd0);
      chk("t3_hold_data",  32'(out_data),  32'd7);
    end
    enable = 1'b0;
    chk("t3_overrun", 32'(overrun), 32'd1);
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("t3_hold2_valid", 32'(out_valid), 32'd1);
      chk("t3_hold2_data",  32'(out_data),  32'd7);
    end
    chk("t3_overrun_sticky", 32'(overrun), 32'd1);
    read_words("t3", 1'b0, '0, 0);
    chk("t3_overrun_after", 32'(overrun), 32'd1);

    // Reset during word ch2, then a full new window before any output.
    enable = 1'b1;
    out_ready = 1'b1;
    tick();
    feed_ramp(0, WL);
    set_ramp(3000, 0);
    tick();
    tick();
    chk("t6_ch2", 32'(out_ch), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid",   32'(out_valid), 32'd0);
    chk("t6_rst_overrun", 32'(overrun),   32'd0);
    chk("t6_rst_ch",      32'(out_ch),    32'd0);
    chk("t6_rst_data",    32'(out_data),  32'd0);
    tick();
    reset = 1'b1;
    chk("t6_rel_valid", 32'(out_valid), 32'd0);
    tick();
    for (int k = 0; k < WL; k++) begin
      set_ramp(3000, k);
      tick();
      if (k < WL-1) chk("t6_wait_valid", 32'(out_valid), 32'd0);
    end
    enable = 1'b0;
    read_words("t6", 1'b0, '0, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
